// File: rtl/oam_dma_controller.sv
// oam_dma_controller
//   Memory bus master between the CPU port and the sram. While idle, CPU accesses
//   pass straight through to the sram. A CPU write to the DMA register takes over the
//   bus and copies LENGTH bytes from {src_hi,8'h00} to DEST_BASE. Each byte takes two
//   clocks: a READ cycle, because sram reads are combinational, and then a WRITE cycle,
//   because sram writes are clocked.
//
//   state | meaning
//   IDLE  | CPU passthrough; DMA register decoded locally
//   START | one idle bus cycle after a trigger
//   READ  | source byte on the bus, captured into data_buf
//   WRITE | data_buf written to destination, advance byte_cnt
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cpu_address/wdata/RE/WE    CPU access request
//   cpu_rdata                  combinational read data returned to the CPU
//   dma_active                 high while the controller owns the memory bus
//   mem_address/RE/WE          sram control
//   mem_dout, mem_oe           databus drive value and drive enable
//   mem_din                    databus sampled value
module oam_dma_controller #(
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] DEST_BASE    = 16'hFE00,
   parameter int          LENGTH       = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_address,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_RE,
   input  logic        cpu_WE,
   output logic [7:0]  cpu_rdata,
   output logic        dma_active,
   output logic [15:0] mem_address,
   output logic        mem_RE,
   output logic        mem_WE,
   output logic [7:0]  mem_dout,
   output logic        mem_oe,
   input  logic [7:0]  mem_din
);

   typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

   localparam logic [7:0] LAST_CNT = 8'(LENGTH - 1);

   state_t     state, state_nxt;
   logic [7:0] dma_reg;
   logic [7:0] byte_cnt;
   logic [7:0] data_buf;
   logic [7:0] src_hi;
   logic       reg_hit;
   logic       trigger;

   assign reg_hit    = (cpu_address == DMA_REG_ADDR);
   assign trigger    = cpu_WE && reg_hit;
   assign dma_active = (state != IDLE);

   // Sources in the echo region E0..FF map back onto C0..DF.
   assign src_hi = (dma_reg >= 8'hE0) ? (dma_reg - 8'h20) : dma_reg;

   // The register is answered locally; during a transfer the bus belongs to the DMA,
   // so every other CPU read returns open-bus FF.
   assign cpu_rdata = reg_hit ? dma_reg : (dma_active ? 8'hFF : mem_din);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         dma_reg  <= 8'h00;
         byte_cnt <= 8'h00;
         data_buf <= 8'h00;
      end else begin
         state <= state_nxt;
         if (trigger) begin
            dma_reg  <= cpu_wdata;
            byte_cnt <= 8'h00;
         end else if (state == WRITE) begin
            byte_cnt <= byte_cnt + 8'h01;
         end
         if (state == READ) begin
            data_buf <= mem_din;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      mem_address = cpu_address;
      mem_RE      = 1'b0;
      mem_WE      = 1'b0;
      mem_dout    = cpu_wdata;
      mem_oe      = 1'b0;
      case (state)
         IDLE: begin
            if (!reg_hit) begin
               mem_RE = cpu_RE;
               mem_WE = cpu_WE;
               mem_oe = cpu_WE;
            end
         end
         START: begin
            state_nxt = READ;
         end
         READ: begin
            mem_address = {src_hi, byte_cnt};
            mem_RE      = 1'b1;
            state_nxt   = WRITE;
         end
         WRITE: begin
            mem_address = DEST_BASE + {8'h00, byte_cnt};
            mem_WE      = 1'b1;
            mem_oe      = 1'b1;
            mem_dout    = data_buf;
            state_nxt   = (byte_cnt == LAST_CNT) ? IDLE : READ;
         end
         default: state_nxt = IDLE;
      endcase
      // A register write restarts the transfer from any state; a WRITE in progress
      // still completes its sram write on this same edge.
      if (trigger) begin
         state_nxt = START;
      end
   end

endmodule
